// File: rtl/pwm_gen_if.sv
// pwm_gen_if: duty-cycle request handshake (duty_in / duty_vld / duty_rdy).
// master drives the request, slave (pwm_gen) returns ready.
interface pwm_gen_if #(
   parameter int N = 8
) ();
   localparam int W = $clog2(N + 1);

   logic [W-1:0] duty_in;
   logic         duty_vld;
   logic         duty_rdy;

   modport master (
      output duty_in,
      output duty_vld,
      input  duty_rdy
   );

   modport slave (
      input  duty_in,
      input  duty_vld,
      output duty_rdy
   );
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: N-cycle PWM, one-deep pending duty applied at the wrap, drain-on-disable.
// Define PWM_GEN_ONESHOT_EN to add the oneshot input (single-period run).
module pwm_gen #(
   parameter  int N = 8,
   localparam int W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
`ifdef PWM_GEN_ONESHOT_EN
   input  logic         oneshot,
`endif
   pwm_gen_if.slave     duty,
   output logic         pwm,
   output logic         prd_end,
   output logic [W-1:0] cnt,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [W-1:0] LAST = W'(N - 1);
   localparam logic [W-1:0] FULL = W'(N);

   state_t       state, state_n;
   logic [W-1:0] cnt_n;
   logic [W-1:0] act, act_n;
   logic [W-1:0] pend, pend_n;
   logic [W-1:0] sat;
   logic         pend_vld, pend_vld_n;
   logic         pwm_n;
   logic         wrap, take, start, stop;

   assign busy          = (state != IDLE);
   assign wrap          = busy && (cnt == LAST);
   assign prd_end       = wrap;
   assign duty.duty_rdy = !pend_vld;
   assign take          = duty.duty_vld && !pend_vld;
   assign sat           = (duty.duty_in > FULL) ? FULL : duty.duty_in;

`ifdef PWM_GEN_ONESHOT_EN
   logic os, os_n, hold, hold_n;

   // hold blocks a restart after a one-shot until en has been seen low
   assign start = en && !hold;
   assign stop  = wrap && (!en || os);

   always_comb begin
      os_n   = os;
      hold_n = hold && en;
      if (state == IDLE && start)
         os_n = oneshot;
      if (wrap && os) begin
         os_n   = 1'b0;
         hold_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         os   <= 1'b0;
         hold <= 1'b0;
      end else begin
         os   <= os_n;
         hold <= hold_n;
      end
   end
`else
   assign start = en;
   assign stop  = wrap && !en;
`endif

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      act_n      = act;
      pend_n     = pend;
      pend_vld_n = pend_vld;
      unique case (state)
         IDLE: begin
            if (take)
               act_n = sat;
            if (start)
               state_n = RUN;
         end
         RUN, DRAIN: begin
            cnt_n = wrap ? '0 : cnt + W'(1);
            if (take) begin
               pend_n     = sat;
               pend_vld_n = 1'b1;
            end
            if (wrap && pend_vld) begin
               act_n      = pend;
               pend_vld_n = 1'b0;
            end
            if (stop)
               state_n = IDLE;
            else if (en)
               state_n = RUN;
            else
               state_n = DRAIN;
         end
         default: state_n = IDLE;
      endcase
      if (state_n == IDLE)
         cnt_n = '0;
      // registered pwm tracks the next-cycle count so it lines up with cnt
      pwm_n = (state_n != IDLE) && (cnt_n < act_n);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         act      <= '0;
         pend     <= '0;
         pend_vld <= 1'b0;
         pwm      <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         act      <= act_n;
         pend     <= pend_n;
         pend_vld <= pend_vld_n;
         pwm      <= pwm_n;
      end
   end
endmodule
